// File: rtl/debug_pkg.sv
// Shared types and widths for the board-debug step controller.
package debug_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } mode_t;

  localparam int STEP_CNT_W = 16;

endpackage

// File: rtl/debug_step_ctrl_if.sv
// Key inputs, burst length and processor-facing outputs of the debug front end.
interface debug_step_ctrl_if #(
  parameter int N_KEYS = 4
);
  import debug_pkg::*;

  logic [N_KEYS-1:0]     key_n;
  logic [7:0]            burst_len;
  logic [N_KEYS-1:0]     key_level;
  logic [N_KEYS-1:0]     key_press;
  logic [N_KEYS-1:0]     key_release;
  logic                  step_en;
  logic [STEP_CNT_W-1:0] step_count;
  logic [1:0]            mode;

  modport master (
    output key_n, burst_len,
    input  key_level, key_press, key_release, step_en, step_count, mode
  );

  modport slave (
    input  key_n, burst_len,
    output key_level, key_press, key_release, step_en, step_count, mode
  );

endinterface

// File: rtl/key_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release pulses.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk_sys,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s2;

  assign w_s2 = ~r_s2;

  // Sync flops reset to the released level so a key held through reset is re-debounced.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_s1      <= 1'b1;
      r_s2      <= 1'b1;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_key_n;
      r_s2      <= r_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      if (w_s2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_TC) begin
        r_cnt     <= '0;
        r_level   <= w_s2;
        r_press   <= w_s2;
        r_release <= ~w_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/debug_step_ctrl.sv
// Debug front end: debounced keys plus HALT/RUN/BURST processor step-enable generator.
//   state   | meaning
//   HALT    | idle; step key gives one pulse or starts a burst, run key enters RUN
//   RUN     | pulse every RUN_DIV cycles until the run key is pressed again
//   BURST   | pulse every RUN_DIV cycles until the burst count is used up or run key aborts
module debug_step_ctrl
  import debug_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 25000000,
  parameter int STEP_KEY        = 2,
  parameter int RUN_KEY         = 3
) (
  input logic               i_clk_sys,
  input logic               i_rst,
  debug_step_ctrl_if.slave  io_dbg
);

  localparam logic [1:0] S_HALT  = 2'(HALT);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_BURST = 2'(BURST);

  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(RUN_DIV - 1);

  logic [N_KEYS-1:0]     w_level;
  logic [N_KEYS-1:0]     w_press;
  logic [N_KEYS-1:0]     w_release;
  logic                  w_rp;
  logic                  w_sp;

  logic [1:0]            r_mode;
  logic [DIV_W-1:0]      r_div;
  logic [7:0]            r_rem;
  logic                  r_step_en;
  logic [STEP_CNT_W-1:0] r_step_count;

  logic [1:0]            w_mode_n;
  logic [DIV_W-1:0]      w_div_n;
  logic [7:0]            w_rem_n;
  logic                  w_step_n;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .i_clk_sys (i_clk_sys),
      .i_rst     (i_rst),
      .i_key_n   (io_dbg.key_n[g]),
      .o_level   (w_level[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign w_rp = w_press[RUN_KEY];
  assign w_sp = w_press[STEP_KEY];

  // rp is tested first everywhere, so it wins over sp and over a same-cycle terminal count.
  always_comb begin
    w_mode_n = r_mode;
    w_div_n  = r_div;
    w_rem_n  = r_rem;
    w_step_n = 1'b0;
    case (r_mode)
      S_HALT: begin
        if (w_rp) begin
          w_mode_n = S_RUN;
          w_div_n  = '0;
        end else if (w_sp) begin
          w_step_n = 1'b1;
          if (io_dbg.burst_len >= 8'd2) begin
            w_mode_n = S_BURST;
            w_rem_n  = io_dbg.burst_len - 8'd1;
            w_div_n  = '0;
          end
        end
      end
      S_RUN: begin
        if (w_rp) begin
          w_mode_n = S_HALT;
          w_div_n  = '0;
        end else if (r_div == DIV_TC) begin
          w_step_n = 1'b1;
          w_div_n  = '0;
        end else begin
          w_div_n = r_div + DIV_W'(1);
        end
      end
      S_BURST: begin
        if (w_rp) begin
          w_mode_n = S_HALT;
          w_div_n  = '0;
          w_rem_n  = '0;
        end else if (r_div == DIV_TC) begin
          w_step_n = 1'b1;
          w_div_n  = '0;
          w_rem_n  = r_rem - 8'd1;
          if (r_rem == 8'd1) begin
            w_mode_n = S_HALT;
          end
        end else begin
          w_div_n = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_mode_n = S_HALT;
        w_div_n  = '0;
        w_rem_n  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_mode       <= S_HALT;
      r_div        <= '0;
      r_rem        <= '0;
      r_step_en    <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_mode       <= w_mode_n;
      r_div        <= w_div_n;
      r_rem        <= w_rem_n;
      r_step_en    <= w_step_n;
      r_step_count <= r_step_count + STEP_CNT_W'(w_step_n);
    end
  end

  assign io_dbg.key_level   = w_level;
  assign io_dbg.key_press   = w_press;
  assign io_dbg.key_release = w_release;
  assign io_dbg.step_en     = r_step_en;
  assign io_dbg.step_count  = r_step_count;
  assign io_dbg.mode        = r_mode;

endmodule
